uop_buf_arb: RTL and testbench

- Owns the single-port uop buffer RAM (UOP_BUF_SIZE x UOP_BUF_WIDTH).
- Arbitrates each cycle between two requesters:
  - the uop loader, which fills entries sequentially from address 0;
  - the uop fetch stage, which performs random reads.
- Tracks the fill level, blocks reads of unwritten entries, and bounds write starvation.
- Sits between the loader, the RAM macro and the fetch stage.

---
 rtl/uop_buf_arb.sv | 109 ++++++++++
 tb/tb_uop_buf_arb.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/uop_buf_arb.sv
// uop_buf_arb: owns the single-port uop buffer RAM and arbitrates it between
// the sequential uop loader (writes) and the fetch stage (random reads).
// The write pointer doubles as the fill level. Reads of unwritten entries are
// held off. A pending write that keeps losing to reads is forced through after
// STARVE_LIMIT consecutive losses.
module uop_buf_arb #(
  parameter int UOP_BUF_SIZE  = 128,
  parameter int UOP_BUF_WIDTH = 64,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              clear,
  // loader side
  input  logic                              fill_valid,
  input  logic [UOP_BUF_WIDTH-1:0]          fill_data,
  output logic                              fill_ready,
  // fetch side
  input  logic                              rd_req,
  input  logic [$clog2(UOP_BUF_SIZE)-1:0]   rd_addr,
  output logic                              rd_grant,
  output logic [UOP_BUF_WIDTH-1:0]          rd_data,
  output logic                              rd_data_valid,
  // RAM macro side
  output logic                              ram_en,
  output logic                              ram_we,
  output logic [$clog2(UOP_BUF_SIZE)-1:0]   ram_addr,
  output logic [UOP_BUF_WIDTH-1:0]          ram_wdata,
  input  logic [UOP_BUF_WIDTH-1:0]          ram_rdata,
  // status
  output logic [$clog2(UOP_BUF_SIZE):0]     fill_count,
  output logic                              buf_full
);

  localparam int              AW         = $clog2(UOP_BUF_SIZE);
  localparam int              CW         = AW + 1;
  localparam logic [CW-1:0]   SIZE_W     = CW'(UOP_BUF_SIZE);
  localparam logic [3:0]      STARVE_MAX = 4'(STARVE_LIMIT);

  // wp counts 0..SIZE inclusive, so it needs one bit more than the address.
  logic [CW-1:0] wp_q, wp_d;
  logic [3:0]    starve_q, starve_d;
  logic          rd_vld_q, rd_vld_d;

  logic w_el, r_el, wr_wins, wr_gnt, rd_gnt;

  // Eligibility and arbitration; clear suppresses every grant in its cycle.
  always_comb begin
    buf_full = (wp_q == SIZE_W);
    w_el     = fill_valid && !buf_full;
    // Unsigned compare against the current wp: only already-written entries
    // are readable, which also removes any need for a write-to-read bypass.
    r_el     = rd_req && ({1'b0, rd_addr} < wp_q);
    wr_wins  = w_el && (!r_el || (starve_q == STARVE_MAX));
    wr_gnt   = !clear && wr_wins;
    rd_gnt   = !clear && r_el && !wr_wins;
  end

  // RAM port and requester handshakes driven from the grant decision.
  always_comb begin
    fill_ready    = wr_gnt;
    rd_grant      = rd_gnt;
    ram_en        = wr_gnt || rd_gnt;
    ram_we        = wr_gnt;
    ram_addr      = wr_gnt ? wp_q[AW-1:0] : rd_addr;
    ram_wdata     = fill_data;
    rd_data       = ram_rdata;
    // A clear in the cycle after a read grant kills that read's data beat.
    rd_data_valid = rd_vld_q && !clear;
    fill_count    = wp_q;
  end

  // Next-state: fill pointer, starvation counter and read-valid pipeline bit.
  always_comb begin
    wp_d     = wp_q;
    starve_d = starve_q;
    rd_vld_d = rd_gnt;
    if (wr_gnt) begin
      wp_d = wp_q + 1'b1;
    end
    if (!w_el || wr_gnt) begin
      starve_d = '0;
    end else if (starve_q != STARVE_MAX) begin
      starve_d = starve_q + 1'b1;
    end
    if (clear) begin
      wp_d     = '0;
      starve_d = '0;
      rd_vld_d = 1'b0;
    end
  end

  // State registers with synchronous active-high reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; only control state is reset, the RAM macro
  // contents are never scrubbed because reads are gated by wp anyway.
  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q     <= '0;
      starve_q <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      wp_q     <= wp_d;
      starve_q <= starve_d;
      rd_vld_q <= rd_vld_d;
    end
  end

endmodule

// File: tb/tb_uop_buf_arb.sv
// Directed testbench for uop_buf_arb. The stimulus process drives one cycle
// at a time and queues the RAM operation it expects (hand-chosen per vector);
// a negedge monitor pops and compares whenever the DUT shows activity.
module tb_uop_buf_arb;

  localparam int SIZE = 128;
  localparam int W    = 64;
  localparam int AW   = 7;

  logic          clk = 1'b0;
  logic          reset, clear, fill_valid, rd_req;
  logic [W-1:0]  fill_data, rd_data, ram_wdata, ram_rdata;
  logic [AW-1:0] rd_addr, ram_addr;
  logic          fill_ready, rd_grant, rd_data_valid, ram_en, ram_we, buf_full;
  logic [AW:0]   fill_count;

  uop_buf_arb #(.UOP_BUF_SIZE(SIZE), .UOP_BUF_WIDTH(W), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .fill_valid(fill_valid), .fill_data(fill_data), .fill_ready(fill_ready),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_grant(rd_grant),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .fill_count(fill_count), .buf_full(buf_full)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM with one-cycle read latency.
  logic [W-1:0] ram_mem [SIZE];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram_mem[ram_addr] <= ram_wdata;
      else        ram_rdata         <= ram_mem[ram_addr];
    end
  end

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
  } gnt_t;

  gnt_t         gq[$];
  logic [W-1:0] dq[$];
  logic [W-1:0] exp_mem [SIZE];
  gnt_t         mon_g;
  int           tb_wp = 0;
  int           gen = 0;
  int           n_checks = 0;
  int           n_errors = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] pat(input int a, input int g);
    return {32'hA000_0000 + 32'(g), 32'h5A5A_0000 | 32'(a)};
  endfunction

  // exp: 0 = no RAM access, 1 = write to next fill slot, 2 = read of ra
  task automatic step(input logic fv, input logic rq, input int ra,
                      input logic clr, input int exp);
    fill_valid = fv;
    fill_data  = pat(tb_wp, gen);
    rd_req     = rq;
    rd_addr    = AW'(ra);
    clear      = clr;
    if (clr) dq.delete();
    if (exp == 1) begin
      gq.push_back(gnt_t'{1'b1, AW'(tb_wp), pat(tb_wp, gen)});
      exp_mem[tb_wp] = pat(tb_wp, gen);
      tb_wp++;
    end else if (exp == 2) begin
      gq.push_back(gnt_t'{1'b0, AW'(ra), '0});
      dq.push_back(exp_mem[ra]);
    end
    @(posedge clk); #1;
    if (clr) begin
      tb_wp = 0;
      gen++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; clear = 1'b0; fill_valid = 1'b0; rd_req = 1'b0;
    rd_addr = '0; fill_data = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    gq.delete();
    dq.delete();
    tb_wp = 0;
    gen++;
  endtask

  // Monitor: compare every RAM access and every read-data beat.
  always @(negedge clk) begin
    if (!reset) begin
      if (ram_en) begin
        if (gq.size() == 0) begin
          check("spurious_ram_en", ram_en, 1'b0);
        end else begin
          mon_g = gq.pop_front();
          check("ram_we", ram_we, mon_g.we);
          check("ram_addr", ram_addr, mon_g.addr);
          check("fill_ready", fill_ready, mon_g.we);
          check("rd_grant", rd_grant, !mon_g.we);
          if (mon_g.we) check("ram_wdata", ram_wdata, mon_g.data);
        end
      end else begin
        check("idle_fill_ready", fill_ready, 1'b0);
        check("idle_rd_grant", rd_grant, 1'b0);
      end
      if (rd_data_valid) begin
        if (dq.size() == 0) check("spurious_rd_data_valid", rd_data_valid, 1'b0);
        else                check("rd_data", rd_data, dq.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    do_reset();
    check("reset_fill_count", fill_count, 0);
    check("reset_buf_full", buf_full, 1'b0);
    check("reset_rd_data_valid", rd_data_valid, 1'b0);

    // Sequential fill of three entries.
    repeat (3) step(1'b1, 1'b0, 0, 1'b0, 1);
    check("fill3_count", fill_count, 3);
    check("fill3_full", buf_full, 1'b0);

    // Read of a written entry; data beat follows a cycle later.
    step(1'b0, 1'b1, 1, 1'b0, 2);
    step(1'b0, 1'b0, 0, 1'b0, 0);

    // Read of unwritten entry 5 is held off until wp reaches 6.
    step(1'b0, 1'b1, 5, 1'b0, 0);
    repeat (3) step(1'b1, 1'b1, 5, 1'b0, 1);
    step(1'b0, 1'b1, 5, 1'b0, 2);
    step(1'b0, 1'b0, 0, 1'b0, 0);
    check("held_read_count", fill_count, 6);

    // Contention: reads win four times, then the starved write goes through.
    for (int c = 1; c <= 10; c++) step(1'b1, 1'b1, 2, 1'b0, (c % 5 == 0) ? 1 : 2);
    step(1'b0, 1'b0, 0, 1'b0, 0);
    check("starve_count", fill_count, 8);

    // Fill to full; further fills are refused, all entries are readable.
    while (tb_wp < SIZE) step(1'b1, 1'b0, 0, 1'b0, 1);
    check("full_count", fill_count, SIZE);
    check("full_flag", buf_full, 1'b1);
    repeat (2) step(1'b1, 1'b0, 0, 1'b0, 0);
    for (int a = 0; a < SIZE; a++) step(1'b1, 1'b1, a, 1'b0, 2);
    step(1'b0, 1'b0, 0, 1'b0, 0);
    check("full_count_after", fill_count, SIZE);

    // Clear right after a read grant kills the data beat and empties the buffer.
    step(1'b0, 1'b1, 3, 1'b0, 2);
    step(1'b1, 1'b0, 0, 1'b1, 0);
    check("clear_fill_count", fill_count, 0);
    check("clear_buf_full", buf_full, 1'b0);
    check("clear_rd_data_valid", rd_data_valid, 1'b0);
    step(1'b1, 1'b0, 0, 1'b0, 1);
    step(1'b0, 1'b1, 0, 1'b0, 2);
    step(1'b0, 1'b0, 0, 1'b0, 0);

    // Reset mid-fill discards entries; next write restarts at address 0.
    step(1'b1, 1'b0, 0, 1'b0, 1);
    check("prereset_count", fill_count, 2);
    do_reset();
    check("midreset_count", fill_count, 0);
    step(1'b1, 1'b0, 0, 1'b0, 1);
    step(1'b0, 1'b1, 0, 1'b0, 2);
    repeat (2) step(1'b0, 1'b0, 0, 1'b0, 0);
    check("final_count", fill_count, 1);

    check("pending_grants", gq.size(), 0);
    check("pending_data", dq.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
